paint_cursor_ctrl: RTL
======================

Name: paint_cursor_ctrl

Overview:
Sits between the joystick interface and the VGA paint screen. Turns raw 10-bit joystick X/Y samples into a clamped on-screen cursor position at a fixed frame-tick rate. While the tool is on, it emits one brush stamp per tick at the cursor as a stream of pixel-write requests (valid/ready) to the framebuffer writer inside the screen block.

Parameters:
H_RES, 640, horizontal pixels; cursor x range 0..H_RES-1
V_RES, 480, vertical pixels; cursor y range 0..V_RES-1
TICK_DIV, 1666667, clk cycles per update tick (60 Hz at 100 MHz)
CENTER, 512, joystick raw rest value
DEAD, 48, deadzone half-width around CENTER
VSHIFT, 5, velocity = (raw-CENTER) >>> VSHIFT (arithmetic)
BIG_SIZE, 4, big-brush edge length in pixels (small brush = 1)

Ports:
clk  in  1  100 MHz system clock
clr  in  1  asynchronous, active-low reset
x_raw  in  10  joystick X sample, 0..1023
y_raw  in  10  joystick Y sample, 0..1023 (larger = up)
tool_on  in  1  level; 1 = paint while moving
size_sel  in  1  debounced single-cycle pulse; toggles brush size
color  in  3  current colour code
cur_x  out  10  cursor x
cur_y  out  10  cursor y
big_brush  out  1  0 = 1x1 brush, 1 = BIG_SIZE x BIG_SIZE brush
wr_valid  out  1  pixel write request
wr_ready  in  1  framebuffer accepts when wr_valid & wr_ready
wr_x  out  10  write pixel x
wr_y  out  10  write pixel y
wr_color  out  3  write colour
busy  out  1  1 while in MOVE or PAINT
overrun  out  1  sticky; a tick arrived while one was already pending

Behaviour:
- Reset (clr=0, async): cur_x=H_RES/2, cur_y=V_RES/2, big_brush=0, wr_valid=0, wr_x/wr_y/wr_color=0, busy=0, overrun=0, tick counter=0, pending=0, FSM=IDLE.
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick = 1-cycle pulse at wrap. It runs continuously, independent of the FSM.
- pending: set on tick, cleared when IDLE consumes it. A tick while pending=1 sets overrun (sticky until reset); the extra tick is dropped.
- size_sel pulse toggles big_brush in any state. The size used for a stamp is latched at PAINT entry.
- FSM IDLE: if pending, clear it and go to MOVE. Else stay.
- FSM MOVE (1 cycle):
  - dx = x_raw-CENTER, dy = y_raw-CENTER, as 11-bit signed.
  - If |d| <= DEAD then d=0, else d = d >>> VSHIFT.
  - nx = cur_x+dx, ny = cur_y-dy, in 12-bit signed. Clamp to [0,H_RES-1] and [0,V_RES-1].
  - Register nx/ny into cur_x/cur_y at the end of MOVE.
  - Next state: PAINT if tool_on, else IDLE.
- FSM PAINT:
  - Latch the stamp origin (new cur_x, cur_y), color and size N (1 or BIG_SIZE) on entry.
  - Iterate offsets (i,j), j outer, i inner, 0..N-1. Pixel = (ox+i, oy+j).
  - Pixels with x>=H_RES or y>=V_RES are skipped with no write; one cycle per skipped pixel.
  - For in-range pixels, drive wr_valid=1 with wr_x/wr_y/wr_color stable until wr_ready. Advance on handshake only.
  - After the last pixel, return to IDLE with wr_valid=0.
  - tool_on falling mid-stamp does not abort; the stamp completes.
- wr_valid never drops without a handshake, except on reset. Reset mid-PAINT abandons the stamp immediately.
- busy=1 in MOVE and PAINT. cur_x/cur_y update only in MOVE.
- Latency: a tick reaches IDLE→MOVE in 1 cycle. The first wr_valid is asserted 2 cycles after the tick pulse.

Decomposition:
- Shared package paint_pkg: H_RES, V_RES, colour-code constants, FSM state encoding (IDLE, MOVE, PAINT).
- One natural sub-module, axis_step: takes raw, current position and limit, and returns the deadzoned, scaled, clamped next position. Instantiate twice (x, and y with inverted sign).

Test Plan:
- Reset, then x_raw=y_raw=512 for 3 ticks -> cur=(320,240) every tick, wr_valid never asserts with tool_on=0.
- x_raw=1023, y_raw=512, tool_on=0, VSHIFT=5 -> cur_x increases by 15 per tick (511>>>5). After enough ticks it saturates at 639 and never wraps.
- y_raw=0, x_raw=540 (inside deadzone) -> cur_x unchanged; cur_y increases by 16 per tick and clamps at 479.
- tool_on=1, big_brush=1, cur=(638,100), stick centred, wr_ready=1 -> exactly 8 writes, x in {638,639} and y 100..103, in row-major order. The 8 out-of-range pixels are skipped.
- Same stamp with wr_ready held 0 for 5 cycles, then toggled -> wr_x/wr_y/wr_color hold stable while stalled. No pixel is lost or duplicated.
- TICK_DIV=20, wr_ready=0 across two ticks -> overrun=1 and stays 1. Asserting clr=0 mid-PAINT drops wr_valid asynchronously and restores all reset values.

Source files
------------

// File: rtl/paint_pkg.sv
// Shared constants and FSM encoding for the paint cursor controller.
package paint_pkg;

  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  localparam logic [2:0] ColBlack   = 3'd0;
  localparam logic [2:0] ColRed     = 3'd1;
  localparam logic [2:0] ColGreen   = 3'd2;
  localparam logic [2:0] ColYellow  = 3'd3;
  localparam logic [2:0] ColBlue    = 3'd4;
  localparam logic [2:0] ColMagenta = 3'd5;
  localparam logic [2:0] ColCyan    = 3'd6;
  localparam logic [2:0] ColWhite   = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StMove,
    StPaint
  } state_e;

endpackage

// File: rtl/paint_cursor_ctrl_axis_step.sv
// One cursor axis: deadzone, velocity scaling and clamping of the next position.
module axis_step import paint_pkg::*; #(
  parameter int unsigned Limit  = H_RES,
  parameter int unsigned Center = 512,
  parameter int unsigned Dead   = 48,
  parameter int unsigned VShift = 5
) (
  input  logic       invert_i,
  input  logic [9:0] raw_i,
  input  logic [9:0] pos_i,
  output logic [9:0] next_o
);

  logic signed [10:0] diff;
  logic signed [10:0] vel;
  logic        [10:0] mag;
  logic signed [11:0] pos_s;
  logic signed [11:0] step_s;
  logic signed [11:0] nxt;

  always_comb begin
    diff   = $signed({1'b0, raw_i}) - $signed(11'(Center));
    // -512 negates to bit pattern 512, which is correct when read as unsigned
    mag    = diff[10] ? 11'(-diff) : 11'(diff);
    vel    = (mag <= 11'(Dead)) ? 11'sd0 : (diff >>> VShift);
    pos_s  = $signed({2'b00, pos_i});
    step_s = {vel[10], vel};
    nxt    = invert_i ? (pos_s - step_s) : (pos_s + step_s);
    if (nxt[11]) begin
      next_o = '0;
    end else if (nxt > $signed(12'(Limit - 1))) begin
      next_o = 10'(Limit - 1);
    end else begin
      next_o = nxt[9:0];
    end
  end

endmodule

// File: rtl/paint_cursor_ctrl.sv
// Joystick-driven cursor with per-tick brush stamping into a valid/ready pixel-write stream.
module paint_cursor_ctrl import paint_pkg::*; #(
  parameter int unsigned TICK_DIV = 1666667,
  parameter int unsigned CENTER   = 512,
  parameter int unsigned DEAD     = 48,
  parameter int unsigned VSHIFT   = 5,
  parameter int unsigned BIG_SIZE = 4
) (
  input  logic       clk_i,
  input  logic       clr_ni,
  input  logic [9:0] x_raw_i,
  input  logic [9:0] y_raw_i,
  input  logic       tool_on_i,
  input  logic       size_sel_i,
  input  logic [2:0] color_i,
  input  logic       wr_ready_i,
  output logic [9:0] cur_x_o,
  output logic [9:0] cur_y_o,
  output logic       big_brush_o,
  output logic       wr_valid_o,
  output logic [9:0] wr_x_o,
  output logic [9:0] wr_y_o,
  output logic [2:0] wr_color_o,
  output logic       busy_o,
  output logic       overrun_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned OffW = $clog2(BIG_SIZE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            big_q, big_d;
  logic [9:0]      cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [9:0]      ox_q, ox_d, oy_q, oy_d;
  logic [2:0]      col_q, col_d;
  logic            big_stamp_q, big_stamp_d;
  logic [OffW-1:0] i_q, i_d, j_q, j_d;

  logic            tick;
  logic [9:0]      nx, ny;
  logic [OffW-1:0] n_last;
  logic [10:0]     px, py;
  logic            in_range;

  axis_step #(
    .Limit  (H_RES),
    .Center (CENTER),
    .Dead   (DEAD),
    .VShift (VSHIFT)
  ) u_axis_x (
    .invert_i (1'b0),
    .raw_i    (x_raw_i),
    .pos_i    (cur_x_q),
    .next_o   (nx)
  );

  // Screen y grows downward while stick y grows upward.
  axis_step #(
    .Limit  (V_RES),
    .Center (CENTER),
    .Dead   (DEAD),
    .VShift (VSHIFT)
  ) u_axis_y (
    .invert_i (1'b1),
    .raw_i    (y_raw_i),
    .pos_i    (cur_y_q),
    .next_o   (ny)
  );

  assign tick  = (cnt_q == CntMax);
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | tick;
    overrun_d   = overrun_q | (tick & pending_q);
    big_d       = big_q ^ size_sel_i;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    col_d       = col_q;
    big_stamp_d = big_stamp_q;
    i_d         = i_q;
    j_d         = j_q;
    busy_o      = 1'b0;
    wr_valid_o  = 1'b0;
    wr_x_o      = '0;
    wr_y_o      = '0;
    wr_color_o  = '0;

    n_last   = big_stamp_q ? OffW'(BIG_SIZE - 1) : '0;
    px       = 11'(ox_q) + 11'(i_q);
    py       = 11'(oy_q) + 11'(j_q);
    in_range = (px < 11'(H_RES)) && (py < 11'(V_RES));

    unique case (state_q)
      StIdle: begin
        // A tick in this very cycle is consumed directly, giving one-cycle latency.
        if (pending_q || tick) begin
          pending_d = 1'b0;
          state_d   = StMove;
        end
      end
      StMove: begin
        busy_o  = 1'b1;
        cur_x_d = nx;
        cur_y_d = ny;
        if (tool_on_i) begin
          state_d     = StPaint;
          ox_d        = nx;
          oy_d        = ny;
          col_d       = color_i;
          big_stamp_d = big_q;
          i_d         = '0;
          j_d         = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StPaint: begin
        busy_o     = 1'b1;
        wr_valid_o = in_range;
        wr_x_o     = px[9:0];
        wr_y_o     = py[9:0];
        wr_color_o = col_q;
        if (!in_range || wr_ready_i) begin
          if (i_q == n_last) begin
            i_d = '0;
            if (j_q == n_last) begin
              state_d = StIdle;
            end else begin
              j_d = j_q + OffW'(1);
            end
          end else begin
            i_d = i_q + OffW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      big_q       <= 1'b0;
      cur_x_q     <= 10'(H_RES / 2);
      cur_y_q     <= 10'(V_RES / 2);
      ox_q        <= '0;
      oy_q        <= '0;
      col_q       <= '0;
      big_stamp_q <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      big_q       <= big_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      col_q       <= col_d;
      big_stamp_q <= big_stamp_d;
      i_q         <= i_d;
      j_q         <= j_d;
    end
  end

  assign cur_x_o     = cur_x_q;
  assign cur_y_o     = cur_y_q;
  assign big_brush_o = big_q;
  assign overrun_o   = overrun_q;

endmodule
